// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART frame states and default frame geometry
package uart_pkg;

  localparam int UART_DATA_WIDTH    = 8;
  localparam int UART_STOP_WIDTH    = 1;
  localparam int UART_PARITY_WIDTH  = 1;
  localparam int UART_TICKS_PER_BIT = 16;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Width of a counter holding 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// rtl/uart_tx_if.sv - byte-in / serial-out handshake bundle for uart_tx
interface uart_tx_if
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = UART_DATA_WIDTH
);

  logic                  i_tx_start;
  logic [DATA_WIDTH-1:0] i_data_byte;
  logic                  o_tx_data_output;
  logic                  o_tx_busy;
  logic                  o_done_bit;

  modport master (
    output i_tx_start,
    output i_data_byte,
    input  o_tx_data_output,
    input  o_tx_busy,
    input  o_done_bit
  );

  modport slave (
    input  i_tx_start,
    input  i_data_byte,
    output o_tx_data_output,
    output o_tx_busy,
    output o_done_bit
  );

endinterface

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - tick-paced UART transmitter (start, data LSB first, optional parity, stop)
// Even parity bits are present only when UART_TX_PARITY_EN is defined.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH    = UART_DATA_WIDTH,
  parameter int STOP_WIDTH    = UART_STOP_WIDTH,
  parameter int PARITY_WIDTH  = UART_PARITY_WIDTH,
  parameter int TICKS_PER_BIT = UART_TICKS_PER_BIT
) (
  input  logic          i_clock,
  input  logic          i_reset,
  input  logic          i_tick,
  uart_tx_if.slave      tx_if
);

  localparam int TICK_W = cnt_width(TICKS_PER_BIT);
  localparam int BIT_W  = cnt_width(max3(DATA_WIDTH, STOP_WIDTH, PARITY_WIDTH));

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_WIDTH - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_WIDTH - 1);
`ifdef UART_TX_PARITY_EN
  localparam logic [BIT_W-1:0]  PAR_LAST  = BIT_W'(PARITY_WIDTH - 1);
`endif

  uart_state_e           state_q, state_d;
  logic [TICK_W-1:0]     tick_q, tick_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
`ifdef UART_TX_PARITY_EN
  logic [DATA_WIDTH-1:0] data_q, data_d;
`endif
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  tick_end;

  assign tick_end = i_tick && (tick_q == TICK_LAST);

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
`ifdef UART_TX_PARITY_EN
      data_q  <= '0;
`endif
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
`ifdef UART_TX_PARITY_EN
      data_q  <= data_d;
`endif
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
`ifdef UART_TX_PARITY_EN
    data_d  = data_q;
`endif

    if (state_q != IDLE && i_tick) begin
      tick_d = tick_end ? '0 : tick_q + TICK_W'(1);
    end

    unique case (state_q)
      IDLE: begin
        if (tx_if.i_tx_start) begin
          shift_d = tx_if.i_data_byte;
`ifdef UART_TX_PARITY_EN
          data_d  = tx_if.i_data_byte;
`endif
          tick_d  = '0;
          bit_d   = '0;
          state_d = START;
        end
      end
      START: begin
        if (tick_end) state_d = DATA;
      end
      DATA: begin
        if (tick_end) begin
          shift_d = shift_q >> 1;
          if (bit_q == DATA_LAST) begin
            bit_d   = '0;
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (tick_end) begin
          if (bit_q == PAR_LAST) begin
            bit_d   = '0;
            state_d = STOP;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
`endif
      STOP: begin
        if (tick_end) begin
          if (bit_q == STOP_LAST) begin
            bit_d   = '0;
            state_d = IDLE;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so the line moves on the same edge as the FSM.
  always_comb begin
    tx_d = 1'b1;
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_d = ^data_d;
`endif
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_q == STOP) && (state_d == IDLE);
  end

  assign tx_if.o_tx_data_output = tx_q;
  assign tx_if.o_tx_busy        = busy_q;
  assign tx_if.o_done_bit       = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - directed frame checks for uart_tx (either UART_TX_PARITY_EN build)
module tb_uart_tx;
  import uart_pkg::*;

  localparam int TPB = 16;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  logic clk = 1'b0;
  logic rst;
  logic tick;

  int n_checks   = 0;
  int n_errors   = 0;
  int tick_total = 0;
  int cyc        = 0;

  always #5 clk = ~clk;

  uart_tx_if #(.DATA_WIDTH(8)) tx_if ();

  uart_tx #(
    .DATA_WIDTH(8),
    .STOP_WIDTH(1),
    .PARITY_WIDTH(1),
    .TICKS_PER_BIT(TPB)
  ) dut (
    .i_clock(clk),
    .i_reset(rst),
    .i_tick (tick),
    .tx_if  (tx_if)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: sample 1ns after the edge, count the tick the edge consumed, then drive the next tick.
  task automatic step();
    @(posedge clk);
    #1;
    if (tick) tick_total++;
    cyc++;
    tick = (cyc % 3 == 0);
  endtask

  task automatic run_frame(input string tag, input logic [7:0] data, input logic [15:0] exp_bits,
                           input bit hold, input int poke_at, input logic [7:0] poke_data);
    int t0;
    int n;
    int last_n;
    int dones;
    bit finished;
    tx_if.i_data_byte = data;
    tx_if.i_tx_start  = 1'b1;
    step();
    tx_if.i_tx_start = hold;
    t0 = tick_total;
    check({tag, "_start_line"}, tx_if.o_tx_data_output, 0);
    check({tag, "_start_busy"}, tx_if.o_tx_busy, 1);
    dones    = 0;
    finished = 0;
    last_n   = 0;
    for (int c = 0; c < NBITS * TPB * 3 + 60 && !finished; c++) begin
      step();
      n = tick_total - t0;
      if (poke_at >= 0 && n == poke_at && n != last_n) begin
        tx_if.i_data_byte = poke_data;
        if (!hold) tx_if.i_tx_start = 1'b1;
      end else if (!hold) begin
        tx_if.i_tx_start = 1'b0;
      end
      if (n != last_n && n % TPB == TPB / 2)
        check($sformatf("%s_bit%0d", tag, n / TPB), tx_if.o_tx_data_output, exp_bits[n / TPB]);
      if (n == NBITS * TPB) begin
        finished = 1;
        check({tag, "_done"}, tx_if.o_done_bit, 1);
        check({tag, "_busy_fall"}, tx_if.o_tx_busy, 0);
      end else if (tx_if.o_done_bit) begin
        dones++;
      end
      last_n = n;
    end
    check({tag, "_finished"}, finished, 1);
    check({tag, "_early_done"}, dones, 0);
  endtask

  initial begin
    int bad_line;
    int bad_busy;
    int bad_done;
    int t0;

    rst = 1'b1;
    tick = 1'b0;
    tx_if.i_tx_start  = 1'b0;
    tx_if.i_data_byte = 8'h00;
    step();
    step();
    check("rst_line", tx_if.o_tx_data_output, 1);
    check("rst_busy", tx_if.o_tx_busy, 0);
    check("rst_done", tx_if.o_done_bit, 0);

    rst = 1'b0;
    bad_line = 0; bad_busy = 0; bad_done = 0;
    for (int c = 0; c < 2 * NBITS * TPB * 3; c++) begin
      step();
      if (tx_if.o_tx_data_output !== 1'b1) bad_line++;
      if (tx_if.o_tx_busy !== 1'b0) bad_busy++;
      if (tx_if.o_done_bit !== 1'b0) bad_done++;
    end
    check("idle_line", bad_line, 0);
    check("idle_busy", bad_busy, 0);
    check("idle_done", bad_done, 0);

`ifdef UART_TX_PARITY_EN
    run_frame("ea", 8'hEA, {1'b1, 1'b1, 8'hEA, 1'b0}, 0, -1, 8'h00);
    run_frame("55", 8'h55, {1'b1, 1'b0, 8'h55, 1'b0}, 0, -1, 8'h00);
    run_frame("a5", 8'hA5, {1'b1, 1'b0, 8'hA5, 1'b0}, 0, 40, 8'h00);
`else
    run_frame("ea", 8'hEA, {1'b1, 8'hEA, 1'b0}, 0, -1, 8'h00);
    run_frame("55", 8'h55, {1'b1, 8'h55, 1'b0}, 0, -1, 8'h00);
    run_frame("a5", 8'hA5, {1'b1, 8'hA5, 1'b0}, 0, 40, 8'h00);
`endif
    bad_busy = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (tx_if.o_tx_busy !== 1'b0) bad_busy++;
    end
    check("a5_restart_ignored", bad_busy, 0);

`ifdef UART_TX_PARITY_EN
    run_frame("b2b0", 8'h0F, {1'b1, 1'b0, 8'h0F, 1'b0}, 1, 20, 8'hF0);
    run_frame("b2b1", 8'hF0, {1'b1, 1'b0, 8'hF0, 1'b0}, 0, -1, 8'h00);
`else
    run_frame("b2b0", 8'h0F, {1'b1, 8'h0F, 1'b0}, 1, 20, 8'hF0);
    run_frame("b2b1", 8'hF0, {1'b1, 8'hF0, 1'b0}, 0, -1, 8'h00);
`endif

    // Abort during the 4th data bit of 8'hA5 (that bit is 0, so the line must visibly rise).
    tx_if.i_data_byte = 8'hA5;
    tx_if.i_tx_start  = 1'b1;
    step();
    tx_if.i_tx_start = 1'b0;
    t0 = tick_total;
    for (int c = 0; c < TPB * 5 * 3 + 30 && (tick_total - t0) < 4 * TPB + 5; c++) step();
    check("abort_reached", tick_total - t0, 4 * TPB + 5);
    check("abort_pre_line", tx_if.o_tx_data_output, 0);
    rst = 1'b1;
    #1;
    check("abort_line", tx_if.o_tx_data_output, 1);
    check("abort_busy", tx_if.o_tx_busy, 0);
    check("abort_done", tx_if.o_done_bit, 0);
    step();
    step();
    rst = 1'b0;
    bad_done = 0;
    bad_busy = 0;
    for (int c = 0; c < 200; c++) begin
      step();
      if (tx_if.o_done_bit !== 1'b0) bad_done++;
      if (tx_if.o_tx_busy !== 1'b0) bad_busy++;
    end
    check("abort_no_done", bad_done, 0);
    check("abort_stays_idle", bad_busy, 0);
`ifdef UART_TX_PARITY_EN
    run_frame("post", 8'h55, {1'b1, 1'b0, 8'h55, 1'b0}, 0, -1, 8'h00);
`else
    run_frame("post", 8'h55, {1'b1, 8'h55, 1'b0}, 0, -1, 8'h00);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
